// File: rtl/prog3_pkg.sv
// Shared types, constants and the window-match helper for the Program-3 engine.
// Optional macro CYCLE_CNT_EN adds the WR3 state that stores the run's cycle count.
package prog3_pkg;

    localparam int NBYTES   = 32;
    localparam int PAT_ADDR = 32;
    localparam int OUT_BASE = 33;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        WR0,
        WR1,
        WR2,
`ifdef CYCLE_CNT_EN
        WR3,
`endif
        DONE
    } state_t;

    // Number of 5-bit windows w[k+4:k] with k_lo <= k <= k_hi that equal pat.
    function automatic logic [3:0] win_match(input logic [11:0] w,
                                             input logic [4:0]  pat,
                                             input int          k_lo,
                                             input int          k_hi);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) begin
            if (k >= k_lo && k <= k_hi && w[k +: 5] == pat)
                n = n + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, never cleared.
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] core [0:DEPTH-1];

    assign rdata = core[addr];

    always_ff @(posedge clk) begin
        if (we)
            core[addr] <= wdata;
    end

endmodule

// File: rtl/instr_rom.sv
// Instruction ROM; contents are loaded from outside the design, the hardwired sequencer never fetches.
module instr_rom #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] core [0:DEPTH-1];

    assign data = core[addr];

endmodule

// File: rtl/top_level_core.sv
// Program-3 engine: counts 5-bit pattern hits in a 32-byte string and writes three counts back.
// Optional macro CYCLE_CNT_EN also stores the LOAD..WR2 cycle count at OUT_BASE+3.
module top_level_core
    import prog3_pkg::*;
#(
    parameter int DM_DEPTH = 256,
    parameter int IM_DEPTH = 1024,
    parameter int IM_WIDTH = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic done
);

    localparam int AW  = $clog2(DM_DEPTH);
    localparam int IAW = $clog2(IM_DEPTH);

    state_t        state, state_next;
    logic [4:0]    pat;
    logic [4:0]    idx;
    logic [3:0]    prev;
    logic [7:0]    ctb, cto, cts;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata, rdata;
    logic [11:0]   w;
    logic [3:0]    in_cnt, x_cnt;
    logic [IM_WIDTH-1:0] instr_unused;
`ifdef CYCLE_CNT_EN
    logic [7:0]    cyc;
`endif

    data_mem #(.DEPTH(DM_DEPTH)) dm1 (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    instr_rom #(.DEPTH(IM_DEPTH), .WIDTH(IM_WIDTH)) ir_inst (
        .addr (IAW'(0)),
        .data (instr_unused)
    );

    // Crossing windows at idx 0 would see the zeroed prev nibble, so they are excluded.
    assign w      = {prev, rdata};
    assign in_cnt = win_match(w, pat, 0, 3);
    assign x_cnt  = (idx != 5'd0) ? win_match(w, pat, 4, 7) : 4'd0;
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat  <= '0;
            idx  <= '0;
            prev <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    pat  <= rdata[7:3];
                    idx  <= '0;
                    prev <= '0;
                    ctb  <= '0;
                    cto  <= '0;
                    cts  <= '0;
                end
                SCAN: begin
                    ctb  <= ctb + {4'd0, in_cnt};
                    cto  <= cto + {7'd0, (in_cnt != 4'd0)};
                    cts  <= cts + {4'd0, in_cnt} + {4'd0, x_cnt};
                    prev <= rdata[3:0];
                    idx  <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CYCLE_CNT_EN
    // Counts every cycle from LOAD through WR2 of the current run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cyc <= '0;
        else if ((state == IDLE || state == DONE) && req)
            cyc <= '0;
        else if (state != IDLE && state != DONE && state != WR3)
            cyc <= cyc + 8'd1;
    end
`endif

    always_comb begin
        state_next = state;
        we         = 1'b0;
        addr       = AW'(idx);
        wdata      = ctb;
        case (state)
            IDLE, DONE: begin
                if (req)
                    state_next = LOAD;
            end
            LOAD: begin
                addr       = AW'(PAT_ADDR);
                state_next = SCAN;
            end
            SCAN: begin
                if (idx == 5'(NBYTES - 1))
                    state_next = WR0;
            end
            WR0: begin
                we         = 1'b1;
                addr       = AW'(OUT_BASE);
                wdata      = ctb;
                state_next = WR1;
            end
            WR1: begin
                we         = 1'b1;
                addr       = AW'(OUT_BASE + 1);
                wdata      = cto;
                state_next = WR2;
            end
            WR2: begin
                we         = 1'b1;
                addr       = AW'(OUT_BASE + 2);
                wdata      = cts;
`ifdef CYCLE_CNT_EN
                state_next = WR3;
`else
                state_next = DONE;
`endif
            end
`ifdef CYCLE_CNT_EN
            WR3: begin
                we         = 1'b1;
                addr       = AW'(OUT_BASE + 3);
                wdata      = cyc;
                state_next = DONE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_top_level_core.sv
// Scoreboard bench for top_level_core: bit-string reference model, queue of expected results, done-driven monitor.
module tb_top_level_core;
    import prog3_pkg::*;

`ifdef CYCLE_CNT_EN
    localparam int EXP_LAT = 38;
`else
    localparam int EXP_LAT = 37;
`endif

    typedef struct {
        int ctb;
        int cto;
        int cts;
        int start;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic req   = 1'b0;
    logic done;

    exp_t       sb_q[$];
    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         edge_cnt = 0;
    logic [7:0] img [0:255];
    int         last_ctb, last_cto, last_cts;
    logic       done_q;

    top_level_core dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic compare(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Reference: view the string as one 256-bit vector, byte 0 at the MSB end, and slide a 5-bit window.
    function automatic exp_t model();
        exp_t        e;
        logic [255:0] s;
        logic [4:0]   p;
        bit           byte_hit [32];
        e.ctb = 0;
        e.cto = 0;
        e.cts = 0;
        e.start = 0;
        for (int i = 0; i < 32; i++) begin
            s[255 - 8*i -: 8] = img[i];
            byte_hit[i] = 1'b0;
        end
        p = img[PAT_ADDR][7:3];
        for (int pos = 0; pos <= 251; pos++) begin
            if (s[255 - pos -: 5] == p) begin
                e.cts++;
                if (pos % 8 <= 3) begin
                    e.ctb++;
                    byte_hit[pos / 8] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 32; i++)
            if (byte_hit[i]) e.cto++;
        return e;
    endfunction

    task automatic set_byte(input int a, input logic [7:0] v);
        img[a] = v;
        dut.dm1.core[a] = v;
    endtask

    task automatic fill(input logic [4:0] p, input logic [7:0] v);
        for (int i = 0; i < 32; i++) set_byte(i, v);
        set_byte(PAT_ADDR, {p, 3'($urandom)});
    endtask

    task automatic applyStimulus(input bit push);
        exp_t e;
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (push) begin
            e = model();
            e.start = edge_cnt;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, expected done=1", n);
        end
        @(negedge clk);
    endtask

    task automatic checkOutput();
        exp_t e;
        int   diffs;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_done: got done rise, expected none pending");
            return;
        end
        e = sb_q.pop_front();
        compare("ctb", int'(dut.dm1.core[OUT_BASE]), e.ctb);
        compare("cto", int'(dut.dm1.core[OUT_BASE + 1]), e.cto);
        compare("cts", int'(dut.dm1.core[OUT_BASE + 2]), e.cts);
        compare("latency", edge_cnt - e.start + 1, EXP_LAT);
`ifdef CYCLE_CNT_EN
        compare("cycle_count", int'(dut.dm1.core[OUT_BASE + 3]), 36);
`endif
        diffs = 0;
        for (int a = 0; a < 256; a++) begin
            if (a >= OUT_BASE && a <= OUT_BASE + 2) continue;
`ifdef CYCLE_CNT_EN
            if (a == OUT_BASE + 3) continue;
`endif
            if (dut.dm1.core[a] !== img[a]) diffs++;
        end
        compare("mem_untouched", diffs, 0);
        last_ctb = e.ctb;
        last_cto = e.cto;
        last_cts = e.cts;
    endtask

    // Monitor: every rising done is matched against the oldest expected result.
    initial begin
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && done && !done_q) checkOutput();
            done_q = done;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int a = 0; a < 256; a++) set_byte(a, 8'($urandom));
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        compare("reset_done", int'(done), 0);
        compare("reset_state", int'(dut.state), int'(IDLE));
        reset = 1'b1;
        @(negedge clk);

        fill(5'b10101, 8'h55); applyStimulus(1); wait_done();
        fill(5'b00000, 8'h00); applyStimulus(1); wait_done();
        fill(5'b10101, 8'hFF); applyStimulus(1); wait_done();
        fill(5'b11111, 8'h00); set_byte(0, 8'h0F); set_byte(1, 8'h80);
        applyStimulus(1); wait_done();

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++)
                set_byte(i, (r % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 8'h55));
            set_byte(PAT_ADDR, 8'($urandom));
            applyStimulus(1);
            wait_done();
        end

        // Abort at idx 10: results from the previous run must survive.
        for (int i = 0; i < 32; i++) set_byte(i, 8'($urandom));
        set_byte(PAT_ADDR, 8'($urandom));
        applyStimulus(0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        compare("abort_idx", int'(dut.idx), 10);
        reset = 1'b0;
        #1;
        compare("abort_done", int'(done), 0);
        compare("abort_state", int'(dut.state), int'(IDLE));
        repeat (2) @(negedge clk);
        compare("abort_ctb_kept", int'(dut.dm1.core[OUT_BASE]), last_ctb);
        compare("abort_cto_kept", int'(dut.dm1.core[OUT_BASE + 1]), last_cto);
        compare("abort_cts_kept", int'(dut.dm1.core[OUT_BASE + 2]), last_cts);
        reset = 1'b1;
        applyStimulus(1); wait_done();

        // Second req mid-scan is ignored; a req in DONE restarts with fresh data.
        fill(5'b01100, 8'h66);
        applyStimulus(1);
        repeat (15) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        compare("done_holds", int'(done), 1);
        for (int i = 0; i < 32; i++) set_byte(i, 8'($urandom));
        set_byte(PAT_ADDR, 8'($urandom));
        applyStimulus(1);
        compare("done_drop", int'(done), 0);
        wait_done();

        repeat (5) @(negedge clk);
        compare("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
